ddr2_frame_sched: RTL

- Frame-buffer scheduler in front of ddr2_core_driver.
- Arbitrates line-write requests (video-in FIFO side) against line-read requests (video-out FIFO side).
- Issues one-cycle line strobes to the driver and presents the buffer ID and line address for each operation.
- Manages triple-buffer rotation so the display always reads the newest fully written frame.

---
 rtl/ddr2_frame_sched_if.sv | 29 ++
 rtl/ddr2_frame_sched.sv | 138 +++++++++++++
 2 files changed

// File: rtl/ddr2_frame_sched_if.sv
// Handshake bundle between the video FIFOs / DDR2 driver and the frame scheduler.
interface ddr2_frame_sched_if;
  logic       wr_frame_start;
  logic       rd_frame_start;
  logic       wr_line_req;
  logic       rd_line_req;
  logic       drv_done;
  logic       to_ddr2_strb;
  logic       from_ddr2_strb;
  logic [1:0] buf_id;
  logic [9:0] line_addr;
  logic       wr_line_ack;
  logic       rd_line_ack;
  logic       busy;
  logic       err_timeout;
  logic       err_ovr;

  modport master (
    output wr_frame_start, rd_frame_start, wr_line_req, rd_line_req, drv_done,
    input  to_ddr2_strb, from_ddr2_strb, buf_id, line_addr,
    input  wr_line_ack, rd_line_ack, busy, err_timeout, err_ovr
  );

  modport slave (
    input  wr_frame_start, rd_frame_start, wr_line_req, rd_line_req, drv_done,
    output to_ddr2_strb, from_ddr2_strb, buf_id, line_addr,
    output wr_line_ack, rd_line_ack, busy, err_timeout, err_ovr
  );
endinterface

// File: rtl/ddr2_frame_sched.sv
// Round-robin line scheduler for the DDR2 driver with triple-buffer frame rotation.
module ddr2_frame_sched #(
  parameter int LINES_PER_FRAME = 64,
  parameter int TIMEOUT         = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  ddr2_frame_sched_if.slave bus
);
  localparam logic [9:0] LPF = 10'(LINES_PER_FRAME);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY, RECOVER} state_t;
  typedef enum logic {LG_WR, LG_RD} side_t;

  state_t state, state_n;
  side_t  last_grant;
  logic [1:0] wr_buf, rd_buf, done_buf;
  logic [1:0] wr_buf_n, rd_buf_n, done_buf_n;
  logic       new_frame, new_frame_n;
  logic [9:0] wr_cnt, rd_cnt;
  logic [TW-1:0] tmo_cnt;
  logic stale;
  logic wr_elig, rd_elig, go, pick_wr, done_hit, tmo_hit, ovr_hit;
  logic stale_side_fs, wr_inc, rd_inc;

  assign wr_elig = bus.wr_line_req && (wr_cnt < LPF);
  assign rd_elig = bus.rd_line_req && (rd_cnt < LPF);
  assign ovr_hit = (state == IDLE) &&
                   ((bus.wr_line_req && wr_cnt == LPF) || (bus.rd_line_req && rd_cnt == LPF));

  always_comb begin
    state_n  = state;
    go       = 1'b0;
    pick_wr  = 1'b0;
    done_hit = 1'b0;
    tmo_hit  = 1'b0;
    case (state)
      IDLE: if (wr_elig || rd_elig) begin
        go      = 1'b1;
        pick_wr = wr_elig && (!rd_elig || last_grant == LG_RD);
        state_n = GRANT;
      end
      GRANT: state_n = BUSY;
      BUSY: if (bus.drv_done) begin
        done_hit = 1'b1;
        state_n  = RECOVER;
      end else if (tmo_cnt == TMO_LAST) begin
        tmo_hit = 1'b1;
        state_n = RECOVER;
      end
      RECOVER: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Write swap resolves first so a same-cycle read swap sees the fresh frame.
  always_comb begin
    wr_buf_n    = wr_buf;
    rd_buf_n    = rd_buf;
    done_buf_n  = done_buf;
    new_frame_n = new_frame;
    if (bus.wr_frame_start && wr_cnt == LPF) begin
      wr_buf_n    = done_buf;
      done_buf_n  = wr_buf;
      new_frame_n = 1'b1;
    end
    if (bus.rd_frame_start && new_frame_n) begin
      rd_buf_n    = done_buf_n;
      done_buf_n  = rd_buf;
      new_frame_n = 1'b0;
    end
  end

  // A frame start on the op's own side orphans it: completion must not count.
  assign stale_side_fs = (last_grant == LG_WR) ? bus.wr_frame_start : bus.rd_frame_start;
  assign wr_inc = done_hit && last_grant == LG_WR && !stale && wr_cnt < LPF;
  assign rd_inc = done_hit && last_grant == LG_RD && !stale && rd_cnt < LPF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant         <= LG_WR;
      wr_buf             <= 2'd0;
      rd_buf             <= 2'd1;
      done_buf           <= 2'd2;
      new_frame          <= 1'b0;
      wr_cnt             <= '0;
      rd_cnt             <= '0;
      tmo_cnt            <= '0;
      stale              <= 1'b0;
      bus.to_ddr2_strb   <= 1'b0;
      bus.from_ddr2_strb <= 1'b0;
      bus.buf_id         <= '0;
      bus.line_addr      <= '0;
      bus.wr_line_ack    <= 1'b0;
      bus.rd_line_ack    <= 1'b0;
      bus.busy           <= 1'b0;
      bus.err_timeout    <= 1'b0;
      bus.err_ovr        <= 1'b0;
    end else begin
      wr_buf    <= wr_buf_n;
      rd_buf    <= rd_buf_n;
      done_buf  <= done_buf_n;
      new_frame <= new_frame_n;

      if (bus.wr_frame_start) wr_cnt <= '0;
      else if (wr_inc)        wr_cnt <= wr_cnt + 10'd1;
      if (bus.rd_frame_start) rd_cnt <= '0;
      else if (rd_inc)        rd_cnt <= rd_cnt + 10'd1;

      if (state == IDLE)  stale <= go && (pick_wr ? bus.wr_frame_start : bus.rd_frame_start);
      else if (stale_side_fs) stale <= 1'b1;

      if (state == GRANT)     tmo_cnt <= '0;
      else if (state == BUSY) tmo_cnt <= tmo_cnt + 1'b1;

      if (go) begin
        last_grant    <= pick_wr ? LG_WR : LG_RD;
        bus.buf_id    <= pick_wr ? wr_buf : rd_buf;
        bus.line_addr <= pick_wr ? wr_cnt : rd_cnt;
      end

      bus.to_ddr2_strb   <= go && pick_wr;
      bus.from_ddr2_strb <= go && !pick_wr;
      bus.wr_line_ack    <= done_hit && last_grant == LG_WR;
      bus.rd_line_ack    <= done_hit && last_grant == LG_RD;
      bus.busy           <= (state_n != IDLE);
      bus.err_timeout    <= bus.err_timeout | tmo_hit;
      bus.err_ovr        <= bus.err_ovr | ovr_hit;
    end
  end
endmodule
